kugelblitz_rewrite_engine: RTL and testbench

- Per-port, rule-based byte rewrite stage for 512-bit Ethernet AXI-stream.
- Sits between the MAC-side and Corundum-side stream interfaces inside the Kugelblitz offload, one instance per direction per port.
- RULE_COUNT rules, each writing one masked byte at a frame-relative byte offset, including offsets beyond the first beat.
- Adds a registered output stage with backpressure, a per-frame rule snapshot and match statistics.

---
 rtl/kugelblitz_pkg.sv | 16 +
 rtl/kugelblitz_rewrite_lane.sv | 34 +++
 rtl/kugelblitz_rewrite_engine.sv | 176 +++++++++++++++++
 tb/tb_kugelblitz_rewrite_engine.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kugelblitz_pkg.sv
// Shared types for the Kugelblitz rewrite engine: rule record and statistic width.
package kugelblitz_pkg;

  localparam int STAT_WIDTH   = 32;
  localparam int RULE_OFF_W   = 16;
  localparam int RULE_CMP_W   = RULE_OFF_W + 1;

  // Offset field is sized for the widest supported frame offset; narrower configs zero-extend.
  typedef struct packed {
    logic                  enable;
    logic [RULE_OFF_W-1:0] offset;
    logic [7:0]            data;
    logic [7:0]            mask;
  } rule_t;

endpackage

// File: rtl/kugelblitz_rewrite_lane.sv
// One byte lane: applies every rule in order to a single byte at a known frame offset.
module kugelblitz_rewrite_lane
  import kugelblitz_pkg::*;
#(
  parameter int RULE_COUNT   = 4,
  parameter int OFFSET_WIDTH = 11
) (
  input  logic [7:0]          i_byte,
  input  logic                i_keep,
  input  logic                i_global_en,
  input  logic [OFFSET_WIDTH:0] i_offset,
  input  rule_t               i_rules [RULE_COUNT],
  output logic [7:0]          o_byte,
  output logic                o_hit
);

  // Later rules overwrite earlier ones bit-by-bit, so the highest index wins on overlap.
  always_comb begin
    o_byte = i_byte;
    o_hit  = 1'b0;
    if (!i_keep) begin
      o_byte = 8'h00;
    end else if (i_global_en) begin
      for (int r = 0; r < RULE_COUNT; r++) begin
        if (i_rules[r].enable &&
            (RULE_CMP_W'(i_offset) == RULE_CMP_W'(i_rules[r].offset))) begin
          o_byte = (o_byte & ~i_rules[r].mask) | (i_rules[r].data & i_rules[r].mask);
          o_hit  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kugelblitz_rewrite_engine.sv
// Rule-based byte rewrite stage for a 512-bit AXI-stream with a registered output,
// per-frame rule snapshot and frame/hit statistics.
module kugelblitz_rewrite_engine
  import kugelblitz_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int USER_WIDTH     = 81,
  parameter int RULE_COUNT     = 4,
  parameter int OFFSET_WIDTH   = 11,
  parameter int RULE_IDX_WIDTH = (RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic [USER_WIDTH-1:0]     s_axis_tuser,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [USER_WIDTH-1:0]     m_axis_tuser,
  input  logic                      cfg_global_en,
  input  logic                      cfg_wr_en,
  input  logic [RULE_IDX_WIDTH-1:0] cfg_wr_rule,
  input  logic                      cfg_wr_enable,
  input  logic [OFFSET_WIDTH-1:0]   cfg_wr_offset,
  input  logic [7:0]                cfg_wr_data,
  input  logic [7:0]                cfg_wr_mask,
  output logic [STAT_WIDTH-1:0]     stat_frames,
  output logic [STAT_WIDTH-1:0]     stat_hits
);

  localparam int OFF_EXT_W = OFFSET_WIDTH + 1;

  rule_t                   r_live   [RULE_COUNT];
  rule_t                   r_active [RULE_COUNT];
  logic                    r_active_gen;
  logic                    r_sof;
  logic [OFFSET_WIDTH-1:0] r_base;
  logic                    r_frame_hit;

  logic [DATA_WIDTH-1:0]   r_tdata;
  logic [KEEP_WIDTH-1:0]   r_tkeep;
  logic                    r_tvalid;
  logic                    r_tlast;
  logic [USER_WIDTH-1:0]   r_tuser;
  logic [STAT_WIDTH-1:0]   r_stat_frames;
  logic [STAT_WIDTH-1:0]   r_stat_hits;

  rule_t                   w_rules [RULE_COUNT];
  logic                    w_global_en;
  logic                    w_accept;
  logic [DATA_WIDTH-1:0]   w_new_data;
  logic [KEEP_WIDTH-1:0]   w_lane_hit;
  logic                    w_beat_hit;
  logic                    w_frame_hit;
  logic [OFFSET_WIDTH:0]   w_base_sum;
  logic [OFFSET_WIDTH-1:0] w_base_next;
  logic                    w_cfg_valid;

  assign s_axis_tready = !r_tvalid || m_axis_tready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_cfg_valid   = cfg_wr_en && (32'(cfg_wr_rule) < RULE_COUNT);

  // The first beat of a frame must already see the snapshot it is about to load.
  always_comb begin
    for (int r = 0; r < RULE_COUNT; r++) begin
      w_rules[r] = r_sof ? r_live[r] : r_active[r];
    end
    w_global_en = r_sof ? cfg_global_en : r_active_gen;
  end

  for (genvar b = 0; b < KEEP_WIDTH; b++) begin : g_lane
    logic [OFFSET_WIDTH:0] w_lane_offset;
    assign w_lane_offset = {1'b0, r_base} + OFF_EXT_W'(b);

    kugelblitz_rewrite_lane #(
      .RULE_COUNT   (RULE_COUNT),
      .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_lane (
      .i_byte      (s_axis_tdata[8*b +: 8]),
      .i_keep      (s_axis_tkeep[b]),
      .i_global_en (w_global_en),
      .i_offset    (w_lane_offset),
      .i_rules     (w_rules),
      .o_byte      (w_new_data[8*b +: 8]),
      .o_hit       (w_lane_hit[b])
    );
  end

  assign w_beat_hit  = |w_lane_hit;
  assign w_frame_hit = (r_sof ? 1'b0 : r_frame_hit) | w_beat_hit;

  // Base offset saturates so long frames never alias back onto low-offset rules.
  assign w_base_sum  = {1'b0, r_base} + OFF_EXT_W'(KEEP_WIDTH);
  assign w_base_next = w_base_sum[OFFSET_WIDTH] ? '1 : w_base_sum[OFFSET_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < RULE_COUNT; r++) begin
        r_live[r] <= '0;
      end
    end else if (w_cfg_valid) begin
      r_live[cfg_wr_rule] <= '{enable: cfg_wr_enable,
                               offset: RULE_OFF_W'(cfg_wr_offset),
                               data:   cfg_wr_data,
                               mask:   cfg_wr_mask};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < RULE_COUNT; r++) begin
        r_active[r] <= '0;
      end
      r_active_gen  <= 1'b0;
      r_sof         <= 1'b1;
      r_base        <= '0;
      r_frame_hit   <= 1'b0;
      r_stat_frames <= '0;
      r_stat_hits   <= '0;
    end else if (w_accept) begin
      if (r_sof) begin
        for (int r = 0; r < RULE_COUNT; r++) begin
          r_active[r] <= r_live[r];
        end
        r_active_gen <= cfg_global_en;
      end
      if (s_axis_tlast) begin
        r_sof         <= 1'b1;
        r_base        <= '0;
        r_frame_hit   <= 1'b0;
        r_stat_frames <= r_stat_frames + 1'b1;
        if (w_frame_hit) begin
          r_stat_hits <= r_stat_hits + 1'b1;
        end
      end else begin
        r_sof       <= 1'b0;
        r_base      <= w_base_next;
        r_frame_hit <= w_frame_hit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= '0;
    end else if (w_accept) begin
      r_tdata  <= w_new_data;
      r_tkeep  <= s_axis_tkeep;
      r_tvalid <= 1'b1;
      r_tlast  <= s_axis_tlast;
      r_tuser  <= s_axis_tuser;
    end else if (m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign stat_frames   = r_stat_frames;
  assign stat_hits     = r_stat_hits;

endmodule

// File: tb/tb_kugelblitz_rewrite_engine.sv
// Directed bench for the rewrite engine: rule placement, overlap, snapshot timing,
// backpressure, dropped bytes and mid-frame reset.
module tb_kugelblitz_rewrite_engine;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 81;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [UW-1:0] s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic          cfg_global_en;
  logic          cfg_wr_en;
  logic [1:0]    cfg_wr_rule;
  logic          cfg_wr_enable;
  logic [10:0]   cfg_wr_offset;
  logic [7:0]    cfg_wr_data;
  logic [7:0]    cfg_wr_mask;
  logic [31:0]   stat_frames;
  logic [31:0]   stat_hits;

  int    nVectors = 0;
  int    nMiscompares = 0;
  int    expFrames = 0;
  int    expHits = 0;
  beat_t capQ[$];

  always #5 clk = ~clk;

  kugelblitz_rewrite_engine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .cfg_global_en (cfg_global_en),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_rule   (cfg_wr_rule),
    .cfg_wr_enable (cfg_wr_enable),
    .cfg_wr_offset (cfg_wr_offset),
    .cfg_wr_data   (cfg_wr_data),
    .cfg_wr_mask   (cfg_wr_mask),
    .stat_frames   (stat_frames),
    .stat_hits     (stat_hits)
  );

  // Inputs change only just after posedge, so a negedge sample predicts the next handshake.
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      capQ.push_back('{data: m_axis_tdata, keep: m_axis_tkeep, last: m_axis_tlast, user: m_axis_tuser});
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic [UW-1:0] u);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!s_axis_tready) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL send_timeout: s_axis_tready=%0b, required 1 within 500 cycles", s_axis_tready);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] rule, input logic en, input logic [10:0] off,
                           input logic [7:0] data, input logic [7:0] mask);
    cfg_wr_rule   = rule;
    cfg_wr_enable = en;
    cfg_wr_offset = off;
    cfg_wr_data   = data;
    cfg_wr_mask   = mask;
    cfg_wr_en     = 1'b1;
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    while (m_axis_tvalid && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (m_axis_tvalid) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL drain_timeout: m_axis_tvalid=%0b, required 0", m_axis_tvalid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nVectors++;
    if (m_axis_tvalid !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_tvalid: got %0b, want 0", m_axis_tvalid);
    end
    nVectors++;
    if (stat_frames !== 32'd0 || stat_hits !== 32'd0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_stats: got frames=%0d hits=%0d, want 0/0", stat_frames, stat_hits);
    end
    nVectors++;
    if (m_axis_tdata !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_tdata: got %h, want 0", m_axis_tdata);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nVectors++;
    if (s_axis_tready !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL reset_tready: got %0b, want 1", s_axis_tready);
    end
  endtask

  task automatic test_single_beat();
    logic [DW-1:0] exp;
    capQ.delete();
    cfg_write(2'd0, 1'b1, 11'd12, 8'hAB, 8'hFF);
    send_beat({64{8'h11}}, '1, 1'b1, 81'h5);
    drain();
    exp = {64{8'h11}};
    exp[12*8 +: 8] = 8'hAB;
    expFrames++;
    expHits++;
    nVectors++;
    if (capQ.size() != 1 || capQ[0].data !== exp || capQ[0].last !== 1'b1 || capQ[0].user !== 81'h5) begin
      nMiscompares++;
      $display("[TB] FAIL single_beat: got n=%0d data=%h, want n=1 data=%h", capQ.size(),
               capQ.size() > 0 ? capQ[0].data : '0, exp);
    end
    nVectors++;
    if (stat_frames !== 32'(expFrames) || stat_hits !== 32'(expHits)) begin
      nMiscompares++;
      $display("[TB] FAIL single_stats: got %0d/%0d, want %0d/%0d", stat_frames, stat_hits, expFrames, expHits);
    end
  endtask

  task automatic test_second_beat_offset();
    logic [DW-1:0] exp1;
    capQ.delete();
    cfg_write(2'd0, 1'b0, 11'd12, 8'hAB, 8'hFF);
    cfg_write(2'd1, 1'b1, 11'd70, 8'h05, 8'h0F);
    send_beat({64{8'hF0}}, '1, 1'b0, '0);
    send_beat({64{8'hF0}}, '1, 1'b1, '0);
    drain();
    exp1 = {64{8'hF0}};
    exp1[6*8 +: 8] = 8'hF5;
    expFrames++;
    expHits++;
    nVectors++;
    if (capQ.size() != 2 || capQ[0].data !== {64{8'hF0}} || capQ[1].data !== exp1) begin
      nMiscompares++;
      $display("[TB] FAIL offset70: got n=%0d beat1=%h, want n=2 beat1=%h", capQ.size(),
               capQ.size() > 1 ? capQ[1].data : '0, exp1);
    end
    nVectors++;
    if (stat_frames !== 32'(expFrames) || stat_hits !== 32'(expHits)) begin
      nMiscompares++;
      $display("[TB] FAIL offset70_stats: got %0d/%0d, want %0d/%0d", stat_frames, stat_hits, expFrames, expHits);
    end
    capQ.delete();
    cfg_write(2'd1, 1'b1, 11'd200, 8'h05, 8'h0F);
    send_beat({64{8'hF0}}, '1, 1'b0, '0);
    send_beat({64{8'hF0}}, '1, 1'b1, '0);
    drain();
    expFrames++;
    nVectors++;
    if (capQ.size() != 2 || capQ[0].data !== {64{8'hF0}} || capQ[1].data !== {64{8'hF0}}) begin
      nMiscompares++;
      $display("[TB] FAIL offset200: got n=%0d beat1=%h, want untouched", capQ.size(),
               capQ.size() > 1 ? capQ[1].data : '0);
    end
    nVectors++;
    if (stat_frames !== 32'(expFrames) || stat_hits !== 32'(expHits)) begin
      nMiscompares++;
      $display("[TB] FAIL offset200_stats: got %0d/%0d, want %0d/%0d", stat_frames, stat_hits, expFrames, expHits);
    end
  endtask

  task automatic test_overlap();
    logic [DW-1:0] exp;
    capQ.delete();
    cfg_write(2'd0, 1'b1, 11'd3, 8'hFF, 8'hFF);
    cfg_write(2'd1, 1'b1, 11'd3, 8'h00, 8'hF0);
    send_beat({64{8'h5A}}, '1, 1'b1, '0);
    drain();
    exp = {64{8'h5A}};
    exp[3*8 +: 8] = 8'h0F;
    expFrames++;
    expHits++;
    nVectors++;
    if (capQ.size() != 1 || capQ[0].data !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL overlap: got byte3=%h, want 0f", capQ.size() > 0 ? capQ[0].data[3*8 +: 8] : 8'h00);
    end
  endtask

  task automatic test_midframe_write();
    logic [DW-1:0] exp1;
    capQ.delete();
    cfg_write(2'd0, 1'b0, 11'd3, 8'hFF, 8'hFF);
    cfg_write(2'd1, 1'b0, 11'd3, 8'h00, 8'hF0);
    send_beat({64{8'h22}}, '1, 1'b0, '0);
    cfg_wr_rule   = 2'd2;
    cfg_wr_enable = 1'b1;
    cfg_wr_offset = 11'd70;
    cfg_wr_data   = 8'h99;
    cfg_wr_mask   = 8'hFF;
    cfg_wr_en     = 1'b1;
    send_beat({64{8'h22}}, '1, 1'b0, '0);
    cfg_wr_en = 1'b0;
    send_beat({64{8'h22}}, '1, 1'b1, '0);
    drain();
    expFrames++;
    nVectors++;
    if (capQ.size() != 3 || capQ[1].data !== {64{8'h22}} || capQ[2].data !== {64{8'h22}}) begin
      nMiscompares++;
      $display("[TB] FAIL midframe_current: got n=%0d beat1=%h, want untouched", capQ.size(),
               capQ.size() > 1 ? capQ[1].data : '0);
    end
    capQ.delete();
    for (int i = 0; i < 3; i++) begin
      send_beat({64{8'h22}}, '1, (i == 2), '0);
    end
    drain();
    exp1 = {64{8'h22}};
    exp1[6*8 +: 8] = 8'h99;
    expFrames++;
    expHits++;
    nVectors++;
    if (capQ.size() != 3 || capQ[1].data !== exp1 || capQ[0].data !== {64{8'h22}}) begin
      nMiscompares++;
      $display("[TB] FAIL midframe_next: got n=%0d beat1=%h, want %h", capQ.size(),
               capQ.size() > 1 ? capQ[1].data : '0, exp1);
    end
    nVectors++;
    if (stat_frames !== 32'(expFrames) || stat_hits !== 32'(expHits)) begin
      nMiscompares++;
      $display("[TB] FAIL midframe_stats: got %0d/%0d, want %0d/%0d", stat_frames, stat_hits, expFrames, expHits);
    end
  endtask

  task automatic test_backpressure();
    logic stallOk;
    logic [DW-1:0] d [4];
    capQ.delete();
    cfg_write(2'd2, 1'b0, 11'd70, 8'h99, 8'hFF);
    for (int i = 0; i < 4; i++) d[i] = {64{8'(8'h30 + i)}};
    m_axis_tready = 1'b0;
    send_beat(d[0], '1, 1'b0, '0);
    s_axis_tdata  = d[1];
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    stallOk = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== d[0]) stallOk = 1'b0;
    end
    nVectors++;
    if (!stallOk) begin
      nMiscompares++;
      $display("[TB] FAIL stall_hold: got tready=%0b tvalid=%0b data=%h, want 0/1/%h",
               s_axis_tready, m_axis_tvalid, m_axis_tdata, d[0]);
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    for (int i = 1; i < 4; i++) send_beat(d[i], '1, (i == 3), '0);
    drain();
    expFrames++;
    nVectors++;
    if (capQ.size() != 4 || capQ[0].data !== d[0] || capQ[1].data !== d[1] ||
        capQ[2].data !== d[2] || capQ[3].data !== d[3] || capQ[3].last !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL stall_sequence: got %0d beats, want 4 in order", capQ.size());
    end
  endtask

  task automatic test_random_backpressure();
    beat_t expQ[$];
    logic  bpDone;
    int    badBeats;
    capQ.delete();
    cfg_write(2'd0, 1'b1, 11'd0, 8'hEE, 8'hFF);
    cfg_global_en = 1'b0;
    bpDone = 1'b0;
    fork
      begin
        for (int f = 0; f < 100; f++) begin
          int len;
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) begin
            beat_t bt;
            bt.data = {64{8'(f)}};
            bt.data[8 +: 8] = 8'(b);
            bt.keep = '1;
            bt.last = (b == len - 1);
            bt.user = UW'(f * 16 + b);
            expQ.push_back(bt);
            send_beat(bt.data, bt.keep, bt.last, bt.user);
          end
        end
        bpDone = 1'b1;
      end
      begin
        while (!bpDone) begin
          @(posedge clk);
          #1;
          m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    expFrames += 100;
    nVectors++;
    if (capQ.size() != expQ.size()) begin
      nMiscompares++;
      $display("[TB] FAIL random_count: got %0d beats, want %0d", capQ.size(), expQ.size());
    end
    badBeats = 0;
    for (int i = 0; i < expQ.size() && i < capQ.size(); i++) begin
      if (capQ[i] !== expQ[i]) badBeats++;
    end
    nVectors++;
    if (badBeats != 0) begin
      nMiscompares++;
      $display("[TB] FAIL random_data: got %0d bad beats, want 0", badBeats);
    end
    nVectors++;
    if (stat_frames !== 32'(expFrames) || stat_hits !== 32'(expHits)) begin
      nMiscompares++;
      $display("[TB] FAIL random_stats: got %0d/%0d, want %0d/%0d", stat_frames, stat_hits, expFrames, expHits);
    end
    cfg_global_en = 1'b1;
  endtask

  task automatic test_dropped_byte();
    logic [DW-1:0] exp;
    capQ.delete();
    cfg_write(2'd0, 1'b0, 11'd0, 8'hEE, 8'hFF);
    cfg_write(2'd3, 1'b1, 11'd10, 8'h77, 8'hFF);
    send_beat({64{8'h44}}, 64'h0000_0000_0000_000F, 1'b1, '0);
    drain();
    exp = '0;
    exp[31:0] = 32'h4444_4444;
    expFrames++;
    nVectors++;
    if (capQ.size() != 1 || capQ[0].data !== exp || capQ[0].keep !== 64'hF) begin
      nMiscompares++;
      $display("[TB] FAIL dropped_byte: got %h, want %h", capQ.size() > 0 ? capQ[0].data : '0, exp);
    end
    nVectors++;
    if (stat_frames !== 32'(expFrames) || stat_hits !== 32'(expHits)) begin
      nMiscompares++;
      $display("[TB] FAIL dropped_stats: got %0d/%0d, want %0d/%0d", stat_frames, stat_hits, expFrames, expHits);
    end
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] exp;
    send_beat({64{8'h12}}, '1, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    nVectors++;
    if (m_axis_tvalid !== 1'b0 || stat_frames !== 32'd0 || stat_hits !== 32'd0) begin
      nMiscompares++;
      $display("[TB] FAIL midreset: got tvalid=%0b frames=%0d hits=%0d, want 0/0/0",
               m_axis_tvalid, stat_frames, stat_hits);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    capQ.delete();
    cfg_write(2'd0, 1'b1, 11'd5, 8'h55, 8'hFF);
    send_beat({64{8'h66}}, '1, 1'b1, '0);
    drain();
    exp = {64{8'h66}};
    exp[5*8 +: 8] = 8'h55;
    nVectors++;
    if (capQ.size() != 1 || capQ[0].data !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL post_reset_frame: got %h, want %h", capQ.size() > 0 ? capQ[0].data : '0, exp);
    end
    nVectors++;
    if (stat_frames !== 32'd1 || stat_hits !== 32'd1) begin
      nMiscompares++;
      $display("[TB] FAIL post_reset_stats: got %0d/%0d, want 1/1", stat_frames, stat_hits);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    cfg_global_en = 1'b1;
    cfg_wr_en     = 1'b0;
    cfg_wr_rule   = '0;
    cfg_wr_enable = 1'b0;
    cfg_wr_offset = '0;
    cfg_wr_data   = '0;
    cfg_wr_mask   = '0;
    #1;
    test_reset();
    test_single_beat();
    test_second_beat_offset();
    test_overlap();
    test_midframe_write();
    test_backpressure();
    test_random_backpressure();
    test_dropped_byte();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
